// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input (rising edge to
// rising edge), presents each result on parallel registers with a one-cycle
// valid strobe, and retransmits it as a framed MSB-first serial word.
module pwm_capture #(
    parameter int COUNTER_WIDTH = 10,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pwm_i,
    output logic [COUNTER_WIDTH-1:0] high_o,
    output logic [COUNTER_WIDTH-1:0] period_o,
    output logic                     ovf_o,
    output logic                     valid_o,
    output logic                     data_o,
    output logic                     busy_o
);

    localparam int W         = COUNTER_WIDTH;
    localparam int FRAME_W   = 2 * W + 1;
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
    localparam logic [W-1:0]         CNT_MAX  = '1;
    localparam logic [BIT_CNT_W-1:0] BITS_TOP = BIT_CNT_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   pwm_d_reg;
    logic                   pwm_s;
    logic                   rise;

    // Measurement state and result registers
    state_t         state_reg;
    logic [W-1:0]   high_cnt_reg;
    logic [W-1:0]   period_cnt_reg;
    logic [W-1:0]   high_reg;
    logic [W-1:0]   period_reg;
    logic           ovf_reg;
    logic           valid_reg;

    // Serialiser
    logic [FRAME_W-1:0]   frame_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic                 busy_reg;

    assign pwm_s = sync_reg[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_reg;

    // Shift the asynchronous input through the synchroniser chain; keep one
    // extra delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            pwm_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pwm_i};
            pwm_d_reg <= pwm_s;
        end
    end

    // Period/high-time measurement FSM with registered results and strobe.
    // The cycle carrying the rise counts as cycle 1 of the new period, and it
    // is always high, so both counters reload to 1. A rise beats a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            high_cnt_reg   <= '0;
            period_cnt_reg <= '0;
            high_reg       <= '0;
            period_reg     <= '0;
            ovf_reg        <= 1'b0;
            valid_reg      <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        high_cnt_reg   <= W'(1);
                        period_cnt_reg <= W'(1);
                        state_reg      <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        high_reg       <= high_cnt_reg;
                        period_reg     <= period_cnt_reg;
                        ovf_reg        <= 1'b0;
                        valid_reg      <= 1'b1;
                        high_cnt_reg   <= W'(1);
                        period_cnt_reg <= W'(1);
                    end else if (period_cnt_reg == CNT_MAX) begin
                        high_reg       <= high_cnt_reg;
                        period_reg     <= CNT_MAX;
                        ovf_reg        <= 1'b1;
                        valid_reg      <= 1'b1;
                        high_cnt_reg   <= '0;
                        period_cnt_reg <= '0;
                        state_reg      <= IDLE;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                        if (pwm_s && (high_cnt_reg != CNT_MAX)) begin
                            high_cnt_reg <= high_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Frame shifter: a result arriving while idle loads {1, high, period};
    // zeros shift in behind the frame so data_o idles low. Results arriving
    // mid-frame are dropped from the serial path only.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg   <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else if (busy_reg) begin
            frame_reg <= {frame_reg[FRAME_W-2:0], 1'b0};
            if (bit_cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg - 1'b1;
            end
        end else if (valid_reg) begin
            frame_reg   <= {1'b1, high_reg, period_reg};
            bit_cnt_reg <= BITS_TOP;
            busy_reg    <= 1'b1;
        end
    end

    assign high_o   = high_reg;
    assign period_o = period_reg;
    assign ovf_o    = ovf_reg;
    assign valid_o  = valid_reg;
    assign data_o   = frame_reg[FRAME_W-1];
    assign busy_o   = busy_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus for pwm_capture with hand-computed
// expected results; a negedge monitor records every result strobe and every
// serial frame for later comparison.
module tb_pwm_capture;

    localparam int W  = 10;
    localparam int S  = 2;
    localparam int FW = 2 * W + 1;

    logic         clk;
    logic         rst;
    logic         pwm_i;
    logic [W-1:0] high_o;
    logic [W-1:0] period_o;
    logic         ovf_o;
    logic         valid_o;
    logic         data_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Monitor records
    int v_high[$];
    int v_per[$];
    int v_ovf[$];
    int v_cyc[$];
    int f_word[$];
    int f_len[$];
    int f_start[$];

    logic          col_active = 1'b0;
    int            col_len    = 0;
    logic [FW-1:0] col_word   = '0;
    int            rise_k     = 0;

    pwm_capture #(
        .COUNTER_WIDTH(W),
        .SYNC_STAGES  (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_i   (pwm_i),
        .high_o  (high_o),
        .period_o(period_o),
        .ovf_o   (ovf_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Capture result strobes and serial frames away from the active edge
    always @(negedge clk) begin
        if (valid_o) begin
            v_high.push_back(int'(high_o));
            v_per.push_back(int'(period_o));
            v_ovf.push_back(int'(ovf_o));
            v_cyc.push_back(cyc);
        end
        if (rst) begin
            col_active = 1'b0;
        end else if (busy_o) begin
            if (!col_active) begin
                col_active = 1'b1;
                col_len    = 0;
                col_word   = '0;
                f_start.push_back(cyc);
            end
            col_word = {col_word[FW-2:0], data_o};
            col_len++;
        end else if (col_active) begin
            col_active = 1'b0;
            f_word.push_back(int'(col_word));
            f_len.push_back(col_len);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] make_frame(input int h, input int p);
        logic [31:0] hv;
        logic [31:0] pv;
        hv = h;
        pv = p;
        return {11'b0, 1'b1, hv[W-1:0], pv[W-1:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_period(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            pwm_i = (i < h);
            tick(1);
        end
    endtask

    task automatic clear_records();
        v_high.delete();
        v_per.delete();
        v_ovf.delete();
        v_cyc.delete();
        f_word.delete();
        f_len.delete();
        f_start.delete();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        pwm_i = 1'b0;
        tick(2);
        rst = 1'b0;
        clear_records();
        tick(3);
    endtask

    task automatic check_results(input string sc, input int h, input int p, input int ovf);
        for (int i = 0; i < v_high.size(); i++) begin
            check($sformatf("%s_high[%0d]", sc, i), v_high[i], h);
            check($sformatf("%s_period[%0d]", sc, i), v_per[i], p);
            check($sformatf("%s_ovf[%0d]", sc, i), v_ovf[i], ovf);
        end
    endtask

    task automatic check_frames(input string sc, input int h, input int p);
        for (int i = 0; i < f_word.size(); i++) begin
            check($sformatf("%s_frame[%0d]", sc, i), f_word[i], make_frame(h, p));
            check($sformatf("%s_flen[%0d]", sc, i), f_len[i], FW);
        end
    endtask

    initial begin
        rst   = 1'b1;
        pwm_i = 1'b0;

        // Reset held 3 cycles with the input toggling
        for (int i = 0; i < 3; i++) begin
            pwm_i = ~pwm_i;
            tick(1);
        end
        @(negedge clk);
        check("rst_high", high_o, 0);
        check("rst_period", period_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pwm_i = 1'b0;
        clear_records();
        tick(3);
        pwm_period(30, 100);
        check("rst_first_rise_novalid", v_high.size(), 0);

        // Steady PWM 30/100: one result per rise from the second rise onward
        for (int i = 0; i < 4; i++) pwm_period(30, 100);
        pwm_i = 1'b0;
        tick(30);
        check("steady_count", v_high.size(), 4);
        check_results("steady", 30, 100, 0);
        for (int i = 1; i < v_cyc.size(); i++)
            check($sformatf("steady_spacing[%0d]", i), v_cyc[i] - v_cyc[i-1], 100);
        check("steady_frames", f_word.size(), 4);
        check_frames("steady", 30, 100);

        // Single serial frame for high=5, period=12, plus edge latency
        do_reset();
        pwm_period(5, 12);
        rise_k = cyc + 1;
        pwm_period(5, 12);
        pwm_i = 1'b0;
        tick(40);
        check("ser_count", v_high.size(), 1);
        check_results("ser", 5, 12, 0);
        check("ser_latency", v_cyc[0], rise_k + S);
        check("ser_frames", f_word.size(), 1);
        check_frames("ser", 5, 12);
        check("ser_start", f_start[0], v_cyc[0] + 1);
        check("ser_idle_busy", busy_o, 0);
        check("ser_idle_data", data_o, 0);

        // Stuck high after a rise: timeout then recovery from the second rise
        do_reset();
        pwm_i = 1'b1;
        tick(1100);
        check("to_count", v_high.size(), 1);
        check_results("to", 1023, 1023, 1);
        check("to_frames", f_word.size(), 1);
        check_frames("to", 1023, 1023);
        pwm_i = 1'b0;
        tick(5);
        for (int i = 0; i < 3; i++) pwm_period(30, 100);
        pwm_i = 1'b0;
        tick(30);
        check("rec_count", v_high.size(), 3);
        if (v_high.size() == 3) begin
            check("rec_high", v_high[2], 30);
            check("rec_period", v_per[2], 100);
            check("rec_ovf", v_ovf[2], 0);
            check("rec_high1", v_high[1], 30);
        end

        // Short periods 4/8: every result on the registers, every third framed
        do_reset();
        for (int i = 0; i < 10; i++) pwm_period(4, 8);
        pwm_i = 1'b0;
        tick(30);
        check("short_count", v_high.size(), 9);
        check_results("short", 4, 8, 0);
        for (int i = 1; i < v_cyc.size(); i++)
            check($sformatf("short_spacing[%0d]", i), v_cyc[i] - v_cyc[i-1], 8);
        check("short_frames", f_word.size(), 3);
        check_frames("short", 4, 8);
        for (int i = 0; i < f_start.size(); i++)
            check($sformatf("short_fstart[%0d]", i), f_start[i], v_cyc[3*i] + 1);

        // Reset in the middle of a period and a frame
        do_reset();
        pwm_period(5, 12);
        for (int i = 0; i < 6; i++) begin
            pwm_i = (i < 5);
            tick(1);
        end
        check("mid_busy_before", busy_o, 1);
        rst   = 1'b1;
        pwm_i = 1'b0;
        tick(1);
        check("mid_busy_after", busy_o, 0);
        check("mid_data_after", data_o, 0);
        check("mid_valid_after", valid_o, 0);
        check("mid_high_after", high_o, 0);
        rst = 1'b0;
        clear_records();
        pwm_i = 1'b0;
        tick(6);
        pwm_period(5, 12);
        pwm_i = 1'b0;
        tick(10);
        check("mid_no_valid", v_high.size(), 0);
        check("mid_no_frame", f_start.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
